// File: rtl/mat_cmd_issuer.sv
// mat_cmd_issuer
//   Host-side initiator of the op/data mailbox in shared matrix memory.
//   Sequence: load operand words into the DATA region, write the op word to
//   OP_ADDR, poll OP_ADDR until the compute side clears it to NONE (0), then
//   stream the RES region out. Sits between the host command/stream
//   interface and a single-port memory arbiter.
//
// Ports
//   clock, reset            clock; asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_op, cmd_dim1, cmd_dim2,
//                           cmd_in_len, cmd_out_len latched on accept
//   in_valid/in_ready       operand stream (in_data)
//   out_valid/out_ready     result stream (out_data, out_last)
//   mem_addr/mem_wdata      memory address / write data
//   mem_read/mem_write      strobes; mem_rdata valid the cycle after mem_read
//   busy                    high from accept until done
//   done                    1-cycle completion pulse
//   err                     1-cycle pulse with done on poll timeout
//
// Optional build macro
//   MAT_CMD_TIMEOUT_EN      enables the 16-bit poll timeout (TIMEOUT_CYCLES);
//                           without it polling never gives up and err is 0.
module mat_cmd_issuer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int DIM_WIDTH      = 4,
  parameter int OP_WIDTH       = 4,
  parameter int OP_ADDR        = 999,
  parameter int DATA_ADDR      = 0,
  parameter int RES_ADDR       = 512,
  parameter int POLL_INTERVAL  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  input  logic [DIM_WIDTH-1:0]  cmd_dim1,
  input  logic [DIM_WIDTH-1:0]  cmd_dim2,
  input  logic [ADDR_WIDTH-1:0] cmd_in_len,
  input  logic [ADDR_WIDTH-1:0] cmd_out_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_ISSUE     = 4'd2;
  localparam logic [3:0] S_POLL_WAIT = 4'd3;
  localparam logic [3:0] S_POLL_RD   = 4'd4;
  localparam logic [3:0] S_DRAIN_RD  = 4'd5;
  localparam logic [3:0] S_DRAIN_CAP = 4'd6;
  localparam logic [3:0] S_DRAIN_OUT = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam int PCW = $clog2(POLL_INTERVAL) + 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_INTERVAL - 2);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]            state;
  logic [OP_WIDTH-1:0]   op_r;
  logic [DIM_WIDTH-1:0]  dim1_r;
  logic [DIM_WIDTH-1:0]  dim2_r;
  logic [ADDR_WIDTH-1:0] in_len_r;
  logic [ADDR_WIDTH-1:0] out_len_r;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] k;
  logic [PCW-1:0]        poll_cnt;
  logic                  poll_chk;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  poll_clear;
  logic                  last_word;

  // poll_chk marks the first POLL_WAIT cycle after a POLL_RD, when the
  // op word read is on mem_rdata; the check shares that idle cycle.
  always_comb begin
    poll_clear = (state == S_POLL_WAIT) && poll_chk &&
                 (mem_rdata[OP_WIDTH-1:0] == '0);
    last_word  = (k == out_len_r - ADDR_WIDTH'(1));
  end

`ifdef MAT_CMD_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_pend;
  logic        err_r;
  assign err = err_r;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LIMIT;
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_r       <= '0;
      dim1_r     <= '0;
      dim2_r     <= '0;
      in_len_r   <= '0;
      out_len_r  <= '0;
      idx        <= '0;
      k          <= '0;
      poll_cnt   <= '0;
      poll_chk   <= 1'b0;
      out_data_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef MAT_CMD_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_pend   <= 1'b0;
      err_r      <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef MAT_CMD_TIMEOUT_EN
      err_r  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r      <= cmd_op;
            dim1_r    <= cmd_dim1;
            dim2_r    <= cmd_dim2;
            in_len_r  <= cmd_in_len;
            out_len_r <= cmd_out_len;
            idx       <= '0;
            k         <= '0;
            poll_cnt  <= '0;
            poll_chk  <= 1'b0;
            busy_r    <= 1'b1;
`ifdef MAT_CMD_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_pend  <= 1'b0;
`endif
            if (cmd_op == '0)
              state <= S_DONE;
            else if (cmd_in_len == '0)
              state <= S_ISSUE;
            else
              state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            idx <= idx + ADDR_WIDTH'(1);
            if (idx == in_len_r - ADDR_WIDTH'(1))
              state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          poll_cnt <= '0;
          state    <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          poll_chk <= 1'b0;
          if (poll_clear) begin
            poll_cnt <= '0;
            state    <= (out_len_r == '0) ? S_DONE : S_DRAIN_RD;
          end else if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
            state    <= S_POLL_RD;
          end else begin
            poll_cnt <= poll_cnt + PCW'(1);
          end
        end
        S_POLL_RD: begin
          poll_chk <= 1'b1;
          state    <= S_POLL_WAIT;
        end
        S_DRAIN_RD: begin
          state <= S_DRAIN_CAP;
        end
        S_DRAIN_CAP: begin
          out_data_r <= mem_rdata;
          state      <= S_DRAIN_OUT;
        end
        S_DRAIN_OUT: begin
          if (out_ready) begin
            if (last_word) begin
              state <= S_DONE;
            end else begin
              k     <= k + ADDR_WIDTH'(1);
              state <= S_DRAIN_RD;
            end
          end
        end
        S_DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
`ifdef MAT_CMD_TIMEOUT_EN
          err_r    <= err_pend;
          err_pend <= 1'b0;
`endif
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef MAT_CMD_TIMEOUT_EN
      // Timeout overrides the poll transitions above; a clear seen in the
      // same cycle still wins so a completed op is never reported as failed.
      if ((state == S_POLL_WAIT) || (state == S_POLL_RD)) begin
        tmo_cnt <= tmo_cnt + 16'd1;
        if ((tmo_cnt == TMO_LIMIT) && !poll_clear) begin
          state    <= S_DONE;
          err_pend <= 1'b1;
          poll_chk <= 1'b0;
        end
      end
`endif
    end
  end

  always_comb begin
    cmd_ready = (state == S_IDLE);
    in_ready  = (state == S_LOAD);
    out_valid = (state == S_DRAIN_OUT);
    out_last  = (state == S_DRAIN_OUT) && last_word;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_LOAD: begin
        mem_addr  = ADDR_WIDTH'(DATA_ADDR) + idx;
        mem_wdata = in_data;
        mem_write = in_valid;
      end
      S_ISSUE: begin
        mem_addr  = ADDR_WIDTH'(OP_ADDR);
        mem_wdata = DATA_WIDTH'({dim2_r, dim1_r, op_r});
        mem_write = 1'b1;
      end
      S_POLL_RD: begin
        mem_addr = ADDR_WIDTH'(OP_ADDR);
        mem_read = 1'b1;
      end
      S_DRAIN_RD: begin
        mem_addr = ADDR_WIDTH'(RES_ADDR) + k;
        mem_read = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data = out_data_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_mat_cmd_issuer.sv
// tb_mat_cmd_issuer
//   Scoreboard bench for mat_cmd_issuer: expected memory writes, result-region
//   reads and output words are queued as each command is set up and popped as
//   the DUT produces them. A behavioural memory clears the op word a fixed
//   number of cycles after it is written (or never, for timeout/reset cases).
module tb_mat_cmd_issuer;

  localparam int OPA   = 999;
  localparam int DATAA = 0;
  localparam int RESA  = 512;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [3:0]  cmd_dim1 = '0;
  logic [3:0]  cmd_dim2 = '0;
  logic [11:0] cmd_in_len = '0;
  logic [11:0] cmd_out_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  mat_cmd_issuer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .DIM_WIDTH(4), .OP_WIDTH(4),
    .OP_ADDR(OPA), .DATA_ADDR(DATAA), .RES_ADDR(RESA),
    .POLL_INTERVAL(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dim1(cmd_dim1), .cmd_dim2(cmd_dim2),
    .cmd_in_len(cmd_in_len), .cmd_out_len(cmd_out_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [0:4095];
  logic [19:0] seed = '0;
  int clr_after = 0;
  int clr_cnt = 0;

  function automatic logic [31:0] res_val(input logic [11:0] a);
    return {seed, a};
  endfunction

  always @(posedge clock) begin
    if (mem_read) begin
      if (mem_addr >= 12'(RESA) && mem_addr < 12'(OPA))
        mem_rdata <= res_val(mem_addr);
      else
        mem_rdata <= mem[mem_addr];
    end
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      if (mem_addr == 12'(OPA) && clr_after > 0) clr_cnt <= clr_after;
    end else if (clr_cnt > 0) begin
      clr_cnt <= clr_cnt - 1;
      if (clr_cnt == 1) mem[OPA] <= '0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_wr [$];
  logic [11:0] exp_rd [$];
  logic [32:0] exp_out [$];

  bit          done_seen = 0;
  bit          exp_err = 0;
  int          n_done = 0, n_out = 0, n_last = 0, n_mem = 0, stall_cnt = 0;
  int          t_done = 0, t_acc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  wr_t         mw;
  logic [11:0] ma;
  logic [32:0] mo;

  always @(negedge clock) begin
    if (mem_read || mem_write) begin
      n_mem++;
      check_val("rw_excl", 64'(mem_read && mem_write), 64'd0);
    end
    if (mem_write) begin
      if (exp_wr.size() == 0) check_val("wr_extra_qsize", 0, 1);
      else begin
        mw = exp_wr.pop_front();
        check_val("wr_addr", 64'(mem_addr), 64'(mw.addr));
        check_val("wr_data", 64'(mem_wdata), 64'(mw.data));
      end
    end
    if (mem_read && mem_addr != 12'(OPA)) begin
      if (exp_rd.size() == 0) check_val("rd_extra_qsize", 0, 1);
      else begin
        ma = exp_rd.pop_front();
        check_val("rd_addr", 64'(mem_addr), 64'(ma));
      end
    end
    if (prev_stall) begin
      check_val("stall_valid", 64'(out_valid), 64'd1);
      check_val("stall_data", 64'(out_data), 64'(prev_data));
      check_val("stall_no_rd", 64'(mem_read), 64'd0);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (prev_stall) stall_cnt++;
    if (out_valid && out_ready) begin
      n_out++;
      if (out_last) n_last++;
      if (exp_out.size() == 0) check_val("out_extra_qsize", 0, 1);
      else begin
        mo = exp_out.pop_front();
        check_val("out_data", 64'(out_data), 64'(mo[31:0]));
        check_val("out_last", 64'(out_last), 64'(mo[32]));
      end
    end
    if (done) begin
      n_done++;
      done_seen = 1;
      t_done = cyc;
      check_val("err_at_done", 64'(err), 64'(exp_err));
    end else if (err) begin
      check_val("err_without_done", 64'(done), 64'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_outputs_check();
    check_val("rst_ctl", 64'({out_valid, out_last, in_ready, mem_read,
                              mem_write, busy, done, err}), 64'd0);
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_addr", 64'(mem_addr), 64'd0);
    check_val("rst_data", {mem_wdata, out_data}, 64'd0);
  endtask

  task automatic start_cmd(input logic [3:0] op, input logic [3:0] d1,
                           input logic [3:0] d2, input int in_len,
                           input int out_len, input bit gaps,
                           input int clr, input bit tmo);
    logic [31:0] words [$];
    logic        hs;
    int          g;
    clr_after = clr;
    seed      = 20'($urandom);
    done_seen = 0;
    n_done = 0; n_out = 0; n_last = 0; n_mem = 0; stall_cnt = 0;
    if (op != 0) begin
      for (int i = 0; i < in_len; i++) begin
        words.push_back($urandom);
        exp_wr.push_back('{addr: 12'(DATAA + i), data: words[i]});
      end
      exp_wr.push_back('{addr: 12'(OPA),
                         data: (32'(d2) << 8) | (32'(d1) << 4) | 32'(op)});
      if (!tmo) begin
        for (int j = 0; j < out_len; j++) begin
          exp_rd.push_back(12'(RESA + j));
          exp_out.push_back({(j == out_len - 1), res_val(12'(RESA + j))});
        end
      end
    end
    cmd_op = op; cmd_dim1 = d1; cmd_dim2 = d2;
    cmd_in_len = 12'(in_len); cmd_out_len = 12'(out_len);
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 50) begin tick(); g++; end
    check_val("cmd_ready_seen", 64'(cmd_ready), 64'd1);
    t_acc = cyc;
    tick();
    cmd_valid = 1'b0;
    if (op != 0) begin
      for (int i = 0; i < in_len; i++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 3)) begin in_valid = 1'b0; tick(); end
        end
        in_valid = 1'b1;
        in_data  = words[i];
        g = 0;
        do begin hs = in_ready; tick(); g++; end while (!hs && g < 100);
        if (!hs) check_val("load_hs_timeout", 64'(hs), 64'd1);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic finish_cmd(input int out_len, input bit stall);
    int g;
    bit stalled;
    g = 0;
    stalled = 0;
    while (!done_seen && g < 3000) begin
      if (stall && !stalled && out_valid) begin
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        stalled = 1;
      end
      tick();
      g++;
    end
    check_val("done_seen", 64'(done_seen), 64'd1);
    repeat (3) tick();
    check_val("done_pulses", 64'(n_done), 64'd1);
    check_val("busy_after", 64'(busy), 64'd0);
    check_val("out_count", 64'(n_out), 64'(out_len));
    check_val("last_count", 64'(n_last), 64'(out_len > 0 ? 1 : 0));
    check_val("wr_left", 64'(exp_wr.size()), 64'd0);
    check_val("rd_left", 64'(exp_rd.size()), 64'd0);
    check_val("out_left", 64'(exp_out.size()), 64'd0);
  endtask

  initial begin
    int g;
    repeat (2) @(posedge clock);
    #1;
    reset_outputs_check();
    reset = 1'b0;
    tick();

    // 2x2 op with full load and four-word drain
    start_cmd(4'd1, 4'd2, 4'd2, 8, 4, 0, 20, 0);
    finish_cmd(4, 0);

    // NONE op: no memory traffic, done two cycles after accept
    start_cmd(4'd0, 4'd3, 4'd3, 5, 5, 0, 20, 0);
    finish_cmd(0, 0);
    check_val("op0_mem", 64'(n_mem), 64'd0);
    check_val("op0_done_lat", 64'(t_done - t_acc), 64'd2);

    // consumer stall during drain
    start_cmd(4'd3, 4'd3, 4'd1, 2, 3, 0, 20, 0);
    finish_cmd(3, 1);
    check_val("stall_cycles", 64'(stall_cnt), 64'd5);

    // operand gaps during load
    start_cmd(4'd2, 4'd4, 4'd5, 6, 2, 1, 20, 0);
    finish_cmd(2, 0);

    // zero-length load and drain
    start_cmd(4'd6, 4'd1, 4'd7, 0, 0, 0, 12, 0);
    finish_cmd(0, 0);

    // reset while polling, then a fresh command
    start_cmd(4'd5, 4'd1, 4'd3, 3, 2, 0, 0, 0);
    g = 0;
    while (exp_wr.size() != 0 && g < 200) begin tick(); g++; end
    check_val("op_word_written", 64'(exp_wr.size()), 64'd0);
    repeat (2) tick();
    check_val("polling_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset_outputs_check();
    exp_rd.delete();
    exp_out.delete();
    reset = 1'b0;
    tick();
    start_cmd(4'd1, 4'd2, 4'd2, 4, 2, 0, 20, 0);
    finish_cmd(2, 0);

`ifdef MAT_CMD_TIMEOUT_EN
    // op word never cleared: timeout with err, no drain
    exp_err = 1;
    start_cmd(4'd7, 4'd1, 4'd1, 1, 3, 0, 0, 1);
    finish_cmd(0, 0);
    exp_err = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
